reg_decoder_n: RTL and testbench
================================

REG_DECODER_N -- requirements
Module: reg_decoder_n

Interface
REQ-001 SHALL have parameter SEL_W, default 2, meaning select width; the block drives 2**SEL_W output lines, legal range 1..5.
REQ-002 SHALL have parameter DIV, default 4, meaning scan period in clock cycles per step, legal range 1..65535.
REQ-003 SHALL have parameter ACT_LOW, default 0; when 1, every bit of o1 is inverted at the port.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  enable; 0 forces all outputs inactive.
REQ-007 SHALL have port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 SHALL have port load  input  1  scan-mode jump request to index i1.
REQ-009 SHALL have port i1  input  SEL_W  select index.
REQ-010 SHALL have port o1  output  2**SEL_W  registered one-hot line select.
REQ-011 SHALL have port idx  output  SEL_W  registered index currently driven on o1.
REQ-012 SHALL have port tick  output  1  one-cycle pulse on each scan advance.
REQ-013 SHALL have port valid  output  1  high when o1 carries an active line.

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 o1 (before ACT_LOW inversion) SHALL be exactly one-hot when valid=1 and all-zero when valid=0, with o1[idx]=1.
REQ-016 Direct mode (en=1, mode=0): i1 sampled at edge n SHALL appear as idx=i1, o1=onehot(i1), valid=1 after edge n; latency 1 cycle; tick=0.
REQ-017 Direct mode SHALL hold the prescaler at 0; load is ignored.
REQ-018 Scan mode (en=1, mode=1): prescaler SHALL count 0..DIV-1, then wrap to 0.
REQ-019 On the edge where prescaler wraps, idx SHALL increment by 1 modulo 2**SEL_W (max wraps to 0), o1 SHALL update the same edge, and tick SHALL be 1 for that one cycle.
REQ-020 DIV=1 SHALL advance idx and assert tick on every scan-mode cycle.
REQ-021 Scan mode with load=1 SHALL set idx=i1, prescaler=0, tick=0 on that edge; load wins over a coincident wrap.
REQ-022 Direct->scan switch SHALL start from current idx with prescaler 0, so the first advance is DIV cycles later.
REQ-023 Scan->direct switch SHALL clear prescaler and apply REQ-016 on the same edge.
REQ-024 en=0 SHALL drive o1 inactive, valid=0, tick=0 after the next edge; idx SHALL hold; prescaler SHALL clear.
REQ-025 en rising SHALL resume per mode with the held idx (scan: first advance after DIV cycles).

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, force idx=0, prescaler=0, tick=0, valid=0, o1 inactive (all 0, or all 1 when ACT_LOW=1).
REQ-027 Reset asserted mid-scan SHALL discard the prescaler count; after release the first advance SHALL occur DIV enabled scan cycles later.
REQ-028 Reset release SHALL be followed by normal operation on the first rising edge with rst=0.

Structure
REQ-029 Package decoder_pkg SHALL hold the mode encodings (MODE_DIRECT=0, MODE_SCAN=1) and the one-hot decode function used here and by later decoders.
REQ-030 The prescaler SHALL be a sub-module scan_tick_gen (parameter DIV; inputs clk, rst, run, clr; output wrap).
REQ-031 The prescaler width SHALL be the minimum bits to hold DIV-1 (at least 1).

Verification
REQ-032 SEL_W=2, direct mode, i1 = 0,1,2,3 on consecutive cycles -> o1 = 0001,0010,0100,1000 each one cycle later, valid=1, tick=0.
REQ-033 SEL_W=2, DIV=4, scan from idx=0 -> tick every 4th cycle, idx 1,2,3,0, o1 1000->0001 on the wrap.
REQ-034 Scan, load=1 with i1=2 on a wrap cycle -> idx=2, o1=0100, tick=0, next advance to 3 exactly 4 cycles later.
REQ-035 en=0 for 3 cycles while idx=3 -> o1=0000, valid=0; en=1 -> o1=1000 next cycle, idx=3.
REQ-036 rst pulsed between clock edges mid-scan -> o1=0000, idx=0 without an edge; ACT_LOW=1 run -> o1=1111.
REQ-037 SEL_W=3, DIV=1 -> idx walks 0..7..0 every cycle, tick high continuously, o1 always one-hot.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: mode encodings and one-hot decode shared by the decoder family
package decoder_pkg;
  localparam int MAX_SEL_W = 5;
  localparam int ONEHOT_W = 1 << MAX_SEL_W;
  typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} mode_e;
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] s);
    return ONEHOT_W'(1) << s;
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: prescaler counting 0..DIV-1 while running, flagging the wrap cycle
module scan_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic wrap
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign wrap = run && cnt == CW'(DIV - 1);
  // count while running; idle, clear or wrap return the count to 0
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!run || clr || wrap) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/reg_decoder_n.sv
// reg_decoder_n: registered one-hot line decoder with direct and auto-scan modes
module reg_decoder_n
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DIV = 4,
  parameter int ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      i1,
  output logic [(1<<SEL_W)-1:0] o1,
  output logic [SEL_W-1:0]      idx,
  output logic                  tick,
  output logic                  valid
);
  localparam int N = 1 << SEL_W;
  logic [N-1:0] oh;
  logic [SEL_W-1:0] nidx;
  logic run, wrap;
  assign run = en && mode == MODE_SCAN;
  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .run(run),
    .clr(load),
    .wrap(wrap)
  );
  // direct mode and scan jumps take i1; a scan wrap steps to the next line
  always_comb nidx = (!run || load) ? i1 : wrap ? idx + SEL_W'(1) : idx;
  // disabled blanks the lines but keeps idx; enabled registers the next line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      oh <= '0;
      tick <= 1'b0;
      valid <= 1'b0;
    end else if (!en) begin
      oh <= '0;
      tick <= 1'b0;
      valid <= 1'b0;
    end else begin
      idx <= nidx;
      oh <= N'(onehot(MAX_SEL_W'(nidx)));
      tick <= run && !load && wrap;
      valid <= 1'b1;
    end
  assign o1 = ACT_LOW != 0 ? ~oh : oh;
endmodule

// File: tb/tb_reg_decoder_n.sv
// tb_reg_decoder_n: three parameterisations checked against a cycle-count reference model
module tb_reg_decoder_n;
  localparam int SW[3] = '{2, 3, 2};
  localparam int DV[3] = '{4, 1, 4};
  localparam int AL[3] = '{0, 0, 1};
  logic clk = 1'b0;
  logic rst, en, mode, load;
  logic [2:0] i1;
  logic [3:0] o1_0, o1_2;
  logic [7:0] o1_1;
  logic [1:0] idx_0, idx_2;
  logic [2:0] idx_1;
  logic tick_0, tick_1, tick_2, valid_0, valid_1, valid_2;
  int cmp = 0;
  int bad = 0;
  int midx[3], since[3];
  bit mtick[3], mvalid[3];

  always #5 clk = ~clk;

  reg_decoder_n #(.SEL_W(2), .DIV(4), .ACT_LOW(0)) d0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .i1(i1[1:0]),
    .o1(o1_0), .idx(idx_0), .tick(tick_0), .valid(valid_0));
  reg_decoder_n #(.SEL_W(3), .DIV(1), .ACT_LOW(0)) d1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .i1(i1),
    .o1(o1_1), .idx(idx_1), .tick(tick_1), .valid(valid_1));
  reg_decoder_n #(.SEL_W(2), .DIV(4), .ACT_LOW(1)) d2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .i1(i1[1:0]),
    .o1(o1_2), .idx(idx_2), .tick(tick_2), .valid(valid_2));

  function automatic logic [31:0] g_o1(input int k);
    return k == 0 ? 32'(o1_0) : k == 1 ? 32'(o1_1) : 32'(o1_2);
  endfunction
  function automatic logic [31:0] g_idx(input int k);
    return k == 0 ? 32'(idx_0) : k == 1 ? 32'(idx_1) : 32'(idx_2);
  endfunction
  function automatic logic [31:0] g_tick(input int k);
    return k == 0 ? 32'(tick_0) : k == 1 ? 32'(tick_1) : 32'(tick_2);
  endfunction
  function automatic logic [31:0] g_valid(input int k);
    return k == 0 ? 32'(valid_0) : k == 1 ? 32'(valid_1) : 32'(valid_2);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[%0d] t=%0t got=%0h exp=%0h", tag, k, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e;
      e = mvalid[k] ? 32'(1) << midx[k] : 32'(0);
      if (AL[k] != 0) e = e ^ ((32'(1) << (1 << SW[k])) - 32'(1));
      chk("o1", k, g_o1(k), e);
      chk("idx", k, g_idx(k), 32'(midx[k]));
      chk("tick", k, g_tick(k), 32'(mtick[k]));
      chk("valid", k, g_valid(k), 32'(mvalid[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      midx[k] = 0;
      since[k] = 0;
      mtick[k] = 0;
      mvalid[k] = 0;
    end
  endtask

  // scan position = scan cycles since the last anchor; every DIV-th one advances the line
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int n, iv;
      n = 1 << SW[k];
      iv = int'(i1) % n;
      mtick[k] = 0;
      if (!en) begin
        mvalid[k] = 0;
        since[k] = 0;
      end else if (!mode || load) begin
        midx[k] = iv;
        mvalid[k] = 1;
        since[k] = 0;
      end else begin
        since[k]++;
        mvalid[k] = 1;
        if (since[k] % DV[k] == 0) begin
          mtick[k] = 1;
          midx[k] = (midx[k] + 1) % n;
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic m, input logic l, input logic [2:0] i);
    en = e;
    mode = m;
    load = l;
    i1 = i;
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  task automatic apulse();
    rst = 1'b1;
    model_reset();
    #1 check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    mode = 1'b0;
    load = 1'b0;
    i1 = '0;
    model_reset();
    #2 check_all();
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 3'(i));
    step(1, 0, 0, 0);
    repeat (8) step(1, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 2);
    repeat (5) step(1, 1, 0, 0);
    step(1, 0, 0, 3);
    repeat (3) step(0, 1, 0, 0);
    repeat (6) step(1, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    apulse();
    repeat (6) step(1, 1, 0, 0);
    step(1, 0, 0, 5);
    repeat (10) step(1, 1, 0, 0);
    repeat (600) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) apulse();
      step(r >= 8, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 3'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
